// File: rtl/stack_seq.sv
// -----------------------------------------------------------------------------
// stack_seq
//   RPN command sequencer placed directly in front of an 8-bit LIFO stack.
//   Accepts PUSH / ADD / SUB / AND / OR / XOR / DUP / DROP commands, pops the
//   operands from the stack, computes the result and pushes it back. A shadow
//   depth counter rejects illegal commands before any stack strobe is issued.
//
//   Handshake: a command transfers on a rising clk edge where
//   cmd_valid & cmd_ready; cmd_ready is high only in IDLE. rsp_valid is a
//   single-cycle pulse with no backpressure; rsp_err qualifies it.
//
//   Optional feature: define STACK_SEQ_SAT_EN to make ADD/SUB saturate
//   (ADD clamps to all-ones, SUB clamps to zero); otherwise they wrap.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   cmd_valid  command present          cmd_ready  sequencer idle
//   cmd_op     0 PUSH 1 ADD 2 SUB 3 AND 4 OR 5 XOR 6 DUP 7 DROP
//   cmd_data   PUSH immediate
//   rsp_valid  completion pulse         rsp_data   value pushed (0 on DROP/err)
//   rsp_err    rejected or stack error  depth      shadow entry count
//   stk_push / stk_pop / stk_din        stack controls
//   stk_dout   stack top-of-stack       stk_error  stack over/underflow flag
//   dbg_state  current FSM state (IDLE=0 POPA=1 POPB=2 PUSH=3 RESP=4)
// -----------------------------------------------------------------------------
module stack_seq #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int CNT_W  = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic [CNT_W-1:0]  depth,
  output logic              stk_push,
  output logic              stk_pop,
  output logic [DATA_W-1:0] stk_din,
  input  logic [DATA_W-1:0] stk_dout,
  input  logic              stk_error,
  output logic [2:0]        dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_POPA = 3'd1,
    S_POPB = 3'd2,
    S_PUSH = 3'd3,
    S_RESP = 3'd4
  } state_e;

  localparam logic [2:0] OP_PUSH = 3'd0;
  localparam logic [2:0] OP_ADD  = 3'd1;
  localparam logic [2:0] OP_SUB  = 3'd2;
  localparam logic [2:0] OP_AND  = 3'd3;
  localparam logic [2:0] OP_OR   = 3'd4;
  localparam logic [2:0] OP_XOR  = 3'd5;
  localparam logic [2:0] OP_DUP  = 3'd6;
  localparam logic [2:0] OP_DROP = 3'd7;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    depth_q, depth_d;
  logic [DATA_W-1:0]   a_q, a_d;      // top operand
  logic [DATA_W-1:0]   b_q, b_d;      // second operand
  logic [2:0]          op_q, op_d;
  logic [DATA_W-1:0]   imm_q, imm_d;
  logic [DATA_W-1:0]   res_q, res_d;  // value reported in RESP
  logic                ill_q, ill_d;  // command was rejected at accept

  logic                legal;
  logic                not_full;
  logic [DATA_W-1:0]   alu_res;
  logic [DATA_W-1:0]   push_val;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      depth_q <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      imm_q   <= '0;
      res_q   <= '0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      depth_q <= depth_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      imm_q   <= imm_d;
      res_q   <= res_d;
      ill_q   <= ill_d;
    end
  end

  // Legality is judged against the shadow depth so the stack never sees
  // a strobe that would over- or underflow it.
  always_comb begin
    not_full = (depth_q < CNT_W'(DEPTH));
    legal    = 1'b0;
    case (cmd_op)
      OP_PUSH: legal = not_full;
      OP_DUP:  legal = not_full && (depth_q != '0);
      OP_DROP: legal = (depth_q != '0);
      default: legal = (depth_q >= CNT_W'(2));
    endcase
  end

  // B is the second entry, A the top: SUB computes second minus top.
  always_comb begin
    alu_res = '0;
    case (op_q)
`ifdef STACK_SEQ_SAT_EN
      OP_ADD: alu_res = ((b_q + a_q) < b_q) ? '1 : (b_q + a_q);
      OP_SUB: alu_res = (b_q < a_q) ? '0 : (b_q - a_q);
`else
      OP_ADD: alu_res = b_q + a_q;
      OP_SUB: alu_res = b_q - a_q;
`endif
      OP_AND: alu_res = b_q & a_q;
      OP_OR:  alu_res = b_q | a_q;
      OP_XOR: alu_res = b_q ^ a_q;
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    case (op_q)
      OP_PUSH: push_val = imm_q;
      OP_DUP:  push_val = a_q;
      default: push_val = alu_res;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    depth_d   = depth_q;
    a_d       = a_q;
    b_d       = b_q;
    op_d      = op_q;
    imm_d     = imm_q;
    res_d     = res_q;
    ill_d     = ill_q;
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;
    rsp_data  = '0;
    rsp_err   = 1'b0;
    stk_push  = 1'b0;
    stk_pop   = 1'b0;
    stk_din   = '0;

    case (state_q)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          op_d  = cmd_op;
          imm_d = cmd_data;
          if (legal) begin
            ill_d   = 1'b0;
            state_d = (cmd_op == OP_PUSH) ? S_PUSH : S_POPA;
          end else begin
            ill_d   = 1'b1;
            res_d   = '0;
            state_d = S_RESP;
          end
        end
      end
      S_POPA: begin
        a_d = stk_dout;
        if (op_q == OP_DUP) begin
          // DUP only reads the top; nothing is removed.
          state_d = S_PUSH;
        end else begin
          stk_pop = 1'b1;
          depth_d = depth_q - CNT_W'(1);
          if (op_q == OP_DROP) begin
            res_d   = '0;
            state_d = S_RESP;
          end else begin
            state_d = S_POPB;
          end
        end
      end
      S_POPB: begin
        b_d     = stk_dout;
        stk_pop = 1'b1;
        depth_d = depth_q - CNT_W'(1);
        state_d = S_PUSH;
      end
      S_PUSH: begin
        stk_push = 1'b1;
        stk_din  = push_val;
        res_d    = push_val;
        depth_d  = depth_q + CNT_W'(1);
        state_d  = S_RESP;
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        rsp_data  = res_q;
        rsp_err   = stk_error | ill_q;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign depth     = depth_q;
  assign dbg_state = state_q;

endmodule
